// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: state encoding, ready levels, default width.
package div_iter_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter_if.sv
// Divide handshake between EX (master) and div_iter (slave).
// annul_i exists only when DIV_ANNUL_EN is defined.
interface div_iter_if
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) ();

  logic                  start_i;
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
`ifdef DIV_ANNUL_EN
  logic                  annul_i;
`endif
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i,
`ifdef DIV_ANNUL_EN
    output annul_i,
`endif
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i,
`ifdef DIV_ANNUL_EN
    input  annul_i,
`endif
    output result_o, ready_o
  );

endinterface

// File: rtl/div_iter_step.sv
// One restoring division iteration: shift {rem,quo} left, subtract divisor when it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_n,
  output logic [DATA_W-1:0] quo_n
);

  logic [DATA_W:0] rem_sh;

  always_comb begin
    rem_sh = {rem, quo[DATA_W-1]};
    quo_n  = {quo[DATA_W-2:0], 1'b0};
    rem_n  = rem_sh[DATA_W-1:0];
    // Compare on DATA_W+1 bits; the difference always fits DATA_W since it is below divisor.
    if (rem_sh >= {1'b0, divisor}) begin
      rem_n    = rem_sh[DATA_W-1:0] - divisor;
      quo_n[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU), result_o = {remainder, quotient}.
// Optional abort via annul_i when DIV_ANNUL_EN is defined.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem, quo, divisor;
  logic [DATA_W-1:0] rem_n, quo_n;
  logic [DATA_W-1:0] abs1, abs2, rem_fix, quo_fix;
  logic              sign_q, sign_r;
  logic              s1, s2;
  logic              annul;
  logic              accept, zero_div, finish, step;

`ifdef DIV_ANNUL_EN
  assign annul = bus.annul_i;
`else
  assign annul = 1'b0;
`endif

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_n   (rem_n),
    .quo_n   (quo_n)
  );

  always_comb begin
    s1      = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    s2      = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    abs1    = s1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2    = s2 ? -bus.opdata2_i : bus.opdata2_i;
    rem_fix = sign_r ? -rem_n : rem_n;
    quo_fix = sign_q ? -quo_n : quo_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    zero_div = 1'b0;
    finish   = 1'b0;
    step     = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (bus.start_i && !annul) begin
          if (bus.opdata2_i == '0) begin
            zero_div = 1'b1;
            state_n  = DIV_DONE;
          end else begin
            accept  = 1'b1;
            state_n = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (annul) begin
          state_n = DIV_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            finish  = 1'b1;
            state_n = DIV_DONE;
          end
        end
      end
      DIV_DONE: state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      bus.ready_o <= DIV_RESULT_NOT_READY;
      if (zero_div) begin
        bus.result_o <= {bus.opdata1_i, {DATA_W{1'b1}}};
        bus.ready_o  <= DIV_RESULT_READY;
      end
      if (accept) begin
        rem     <= '0;
        quo     <= abs1;
        divisor <= abs2;
        sign_q  <= s1 ^ s2;
        sign_r  <= s1;
        cnt     <= '0;
      end
      if (step) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        bus.result_o <= {rem_fix, quo_fix};
        bus.ready_o  <= DIV_RESULT_READY;
      end
    end
  end

endmodule
